// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction memory loader
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } loader_state_t;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam int          IMEM_DEPTH = 64;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte load port, status and core fetch port of the loader
interface imem_loader_if #(
  parameter int ADDR_W = 6
);

  logic              load_start;
  logic [ADDR_W:0]   load_len;
  logic              load_valid;
  logic [7:0]        load_byte;
  logic              load_ready;
  logic              load_done;
  logic              load_error;
  logic [ADDR_W-1:0] imem_reg;
  logic [31:0]       imem_data;
  logic              core_reset_n;

  modport master (
    output load_start, load_len, load_valid, load_byte, imem_reg,
    input  load_ready, load_done, load_error, imem_data, core_reset_n
  );

  modport slave (
    input  load_start, load_len, load_valid, load_byte, imem_reg,
    output load_ready, load_done, load_error, imem_data, core_reset_n
  );

endinterface

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - word store with synchronous write and asynchronous read, not reset
module imem_ram #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads the instruction store from a byte stream, holds the core in reset meanwhile
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = 6
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  loader_state_t   state, state_next;
  logic [ADDR_W:0] word_cnt;
  logic [ADDR_W:0] len_q;
  logic [1:0]      byte_cnt;
  logic [23:0]     word_buf;
  logic            load_error_q;
  logic            load_done_q;
  logic            start_ok, len_bad, len_zero;
  logic            hs, word_we, last_word;
  logic [31:0]     rdata;

  // A start is only honoured outside LOAD; an in-flight load cannot be restarted.
  assign start_ok  = bus.load_start && (state != LOAD);
  assign len_bad   = bus.load_len > DEPTH_W;
  assign len_zero  = (bus.load_len == '0);
  assign hs        = bus.load_valid && (state == LOAD);
  assign word_we   = hs && (byte_cnt == 2'd3);
  assign last_word = word_we && ((word_cnt + 1'b1) == len_q);

  always_comb begin
    state_next = state;
    case (state)
      IDLE, RUN: begin
        if (bus.load_start) begin
          if (len_bad) begin
            state_next = IDLE;
          end else if (len_zero) begin
            state_next = RUN;
          end else begin
            state_next = LOAD;
          end
        end
      end
      LOAD: begin
        if (last_word) begin
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      word_cnt     <= '0;
      len_q        <= '0;
      byte_cnt     <= '0;
      word_buf     <= '0;
      load_error_q <= 1'b0;
      load_done_q  <= 1'b0;
    end else begin
      state       <= state_next;
      load_done_q <= last_word;
      if (start_ok) begin
        load_error_q <= len_bad;
        word_cnt     <= '0;
        byte_cnt     <= '0;
        if (!len_bad) begin
          len_q <= bus.load_len;
        end
      end else if (hs) begin
        byte_cnt <= byte_cnt + 1'b1;
        // The fourth byte bypasses the buffer and goes straight into the write word.
        case (byte_cnt)
          2'd0:    word_buf[7:0]   <= bus.load_byte;
          2'd1:    word_buf[15:8]  <= bus.load_byte;
          2'd2:    word_buf[23:16] <= bus.load_byte;
          default: word_cnt        <= word_cnt + 1'b1;
        endcase
      end
    end
  end

  imem_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (word_we),
    .waddr (word_cnt[ADDR_W-1:0]),
    .wdata ({bus.load_byte, word_buf}),
    .raddr (bus.imem_reg),
    .rdata (rdata)
  );

  assign bus.load_ready   = (state == LOAD);
  assign bus.core_reset_n = (state == RUN);
  assign bus.load_done    = load_done_q;
  assign bus.load_error   = load_error_q;
  assign bus.imem_data    = (state == RUN) ? rdata : NOP_INSTR;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader with directed load sequences
module tb_imem_loader;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] val;
  } exp_t;

  localparam int SIG_DATA  = 0;
  localparam int SIG_ERROR = 1;
  localparam int SIG_READY = 2;
  localparam int SIG_CRN   = 3;
  localparam int SIG_DONE  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   passes = 0;

  exp_t exp_q[$];
  int   done_q[$];

  imem_loader_if #(.ADDR_W(6)) bus ();

  imem_loader #(.DEPTH(64), .ADDR_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      SIG_DATA:  return bus.imem_data;
      SIG_ERROR: return {31'b0, bus.load_error};
      SIG_READY: return {31'b0, bus.load_ready};
      SIG_CRN:   return {31'b0, bus.core_reset_n};
      default:   return {31'b0, bus.load_done};
    endcase
  endfunction

  // Monitor: samples mid-cycle, pops pending expectations and checks load_done timing.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    int          d;
    if (bus.load_done) begin
      total++;
      if (done_q.size() == 0) begin
        $display("FAIL load_done_unexpected: pulse at cycle %0d, required none", cyc);
      end else begin
        d = done_q.pop_front();
        if (d == cyc) passes++;
        else $display("FAIL load_done_cycle: got cycle %0d, required %0d", cyc, d);
      end
      total++;
      if (bus.core_reset_n === 1'b1) passes++;
      else $display("FAIL done_core_reset_n: got %b, required 1", bus.core_reset_n);
    end
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = observe(e.sig);
      total++;
      if (act === e.val) passes++;
      else $display("FAIL %s: got %h, required %h", e.name, act, e.val);
    end
  end

  task automatic expect_sig(input string name, input int sig, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int len, input int done_after);
    bus.load_start = 1'b1;
    bus.load_len   = 7'(len);
    if (done_after > 0) done_q.push_back(cyc + done_after);
    tick();
    bus.load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic rdy;
    int   n;
    n = 0;
    bus.load_valid = 1'b1;
    bus.load_byte  = b;
    do begin
      rdy = bus.load_ready;
      tick();
      n++;
    end while (!rdy && n < 50);
    total++;
    if (rdy) passes++;
    else $display("FAIL byte_accept_timeout: byte %h got ready 0, required 1", b);
    bus.load_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic read_word(input string name, input int addr, input logic [31:0] val);
    bus.imem_reg = 6'(addr);
    expect_sig(name, SIG_DATA, val);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.load_start = 1'b0;
    bus.load_len   = '0;
    bus.load_valid = 1'b0;
    bus.load_byte  = '0;
    bus.imem_reg   = '0;

    tick();
    expect_sig("reset_ready", SIG_READY, 32'd0);
    expect_sig("reset_done",  SIG_DONE,  32'd0);
    expect_sig("reset_error", SIG_ERROR, 32'd0);
    expect_sig("reset_crn",   SIG_CRN,   32'd0);
    expect_sig("reset_data",  SIG_DATA,  32'h0000_0013);
    tick();
    reset = 1'b0;
    tick();

    // Two-word load at full rate: done 9 cycles after the start cycle.
    start_load(2, 9);
    expect_sig("load_ready_rise", SIG_READY, 32'd1);
    expect_sig("load_nop_fetch",  SIG_DATA,  32'h0000_0013);
    send_word(32'h0000_0013, 0);
    send_word(32'h0010_0093, 0);
    expect_sig("run_crn", SIG_CRN, 32'd1);
    read_word("full_rate_w0", 0, 32'h0000_0013);
    read_word("full_rate_w1", 1, 32'h0010_0093);

    // Same load with valid toggling every other cycle: done after 16 cycles.
    start_load(2, 16);
    expect_sig("reload_crn_low", SIG_CRN, 32'd0);
    send_word(32'h0000_0013, 1);
    send_word(32'h0010_0093, 1);
    read_word("toggle_w0", 0, 32'h0000_0013);
    read_word("toggle_w1", 1, 32'h0010_0093);

    // Oversize length from RUN: back to IDLE with the error flag.
    start_load(65, 0);
    bus.imem_reg = 6'd1;
    expect_sig("oversize_error", SIG_ERROR, 32'd1);
    expect_sig("oversize_crn",   SIG_CRN,   32'd0);
    expect_sig("oversize_ready", SIG_READY, 32'd0);
    expect_sig("oversize_data",  SIG_DATA,  32'h0000_0013);
    tick();
    start_load(0, 0);
    expect_sig("zero_len_error_clear", SIG_ERROR, 32'd0);
    expect_sig("zero_len_run",         SIG_CRN,   32'd1);
    read_word("zero_len_keep_w1", 1, 32'h0010_0093);

    // Single-word reload from RUN.
    start_load(1, 5);
    expect_sig("reload1_crn_low", SIG_CRN, 32'd0);
    send_word(32'hDDCC_BBAA, 0);
    read_word("reload1_w0", 0, 32'hDDCC_BBAA);
    read_word("reload1_w1", 1, 32'h0010_0093);

    // Reset in the middle of word 1 of a three-word load.
    start_load(3, 0);
    send_word(32'h4433_2211, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    reset = 1'b1;
    expect_sig("midload_reset_ready", SIG_READY, 32'd0);
    expect_sig("midload_reset_crn",   SIG_CRN,   32'd0);
    tick();
    reset = 1'b0;
    tick();
    start_load(0, 0);
    read_word("after_reset_w0", 0, 32'h4433_2211);
    read_word("after_reset_w1", 1, 32'h0010_0093);

    // Full 64-word load of the address pattern, then sweep every address.
    start_load(64, 257);
    for (int i = 0; i < 64; i++) send_word(32'(i), 0);
    for (int i = 0; i < 64; i++) read_word($sformatf("sweep_%0d", i), i, 32'(i));

    repeat (3) tick();
    total++;
    if (done_q.size() == 0) passes++;
    else $display("FAIL load_done_missing: got %0d pending, required 0", done_q.size());

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
